// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl : binary-to-BCD converter with a 5-digit multiplexed
// seven-segment scan and leading-zero blanking.          Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module display_scan_ctrl #(
  parameter logic [18:0] REFRESH_MAX = 19'd480000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] refresh_cnt,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] bin_sr;
  logic [19:0] bcd_sr;
  logic [19:0] bcd_adj;
  logic [3:0]  iter;
  logic [19:0] disp;
  logic [2:0]  scan_idx;
  logic [3:0]  digit;
  logic        blank;
  logic [7:0]  an_nxt;
  logic [6:0]  seg_nxt;

  // Double-dabble correction applied before every shift
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 5; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (load) state_nxt = CONV;
      CONV: begin
        busy = 1'b1;
        if (iter == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_sr <= 16'd0;
      bcd_sr <= 20'd0;
      iter   <= 4'd0;
      disp   <= 20'd0;
    end else begin
      case (state)
        IDLE: if (load) begin
          bin_sr <= value_in;
          bcd_sr <= 20'd0;
          iter   <= 4'd0;
        end
        CONV: begin
          {bcd_sr, bin_sr} <= {bcd_adj[18:0], bin_sr, 1'b0};
          iter             <= iter + 4'd1;
        end
        DONE:    disp <= bcd_sr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      scan_idx <= 3'd0;
    else if (refresh_cnt == REFRESH_MAX)
      scan_idx <= (scan_idx == 3'd4) ? 3'd0 : scan_idx + 3'd1;
  end

  // A slot is blank when it and every higher digit are zero; slot 0 never blanks
  always_comb begin
    digit  = disp[3:0];
    blank  = 1'b0;
    an_nxt = 8'hFE;
    case (scan_idx)
      3'd1: begin digit = disp[7:4];   blank = (disp[19:4]  == 16'd0); an_nxt = 8'hFD; end
      3'd2: begin digit = disp[11:8];  blank = (disp[19:8]  == 12'd0); an_nxt = 8'hFB; end
      3'd3: begin digit = disp[15:12]; blank = (disp[19:12] == 8'd0);  an_nxt = 8'hF7; end
      3'd4: begin digit = disp[19:16]; blank = (disp[19:16] == 4'd0);  an_nxt = 8'hEF; end
      default: ;
    endcase
    case (digit)
      4'd0:    seg_nxt = 7'b1000000;
      4'd1:    seg_nxt = 7'b1111001;
      4'd2:    seg_nxt = 7'b0100100;
      4'd3:    seg_nxt = 7'b0110000;
      4'd4:    seg_nxt = 7'b0011001;
      4'd5:    seg_nxt = 7'b0010010;
      4'd6:    seg_nxt = 7'b0000010;
      4'd7:    seg_nxt = 7'b1111000;
      4'd8:    seg_nxt = 7'b0000000;
      4'd9:    seg_nxt = 7'b0010000;
      default: seg_nxt = 7'h7F;
    endcase
    if (blank) begin
      an_nxt  = 8'hFF;
      seg_nxt = 7'h7F;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      an  <= 8'hFE;
      seg <= 7'b1000000;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl : scoreboard bench for display_scan_ctrl (REFRESH_MAX=3)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] refresh_cnt;
  logic [15:0] value_in;
  logic        load;
  logic        busy, done;
  logic [7:0]  an;
  logic [6:0]  seg;

  int n_chk  = 0;
  int n_fail = 0;
  int sidx   = 0;   // model scan index
  int shown  = 0;   // model display value
  int exp_q[$];     // values expected to appear on the display

  logic [6:0] enc [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  display_scan_ctrl #(.REFRESH_MAX(19'd3)) dut (
    .clk(clk), .rst(rst), .refresh_cnt(refresh_cnt), .value_in(value_in),
    .load(load), .busy(busy), .done(done), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] model(input int val, input int idx);
    int p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
    if (idx > 0 && val < p) return {8'hFF, 7'h7F};
    return {~(8'b1 << idx), enc[(val / p) % 10]};
  endfunction

  task automatic tick();
    @(negedge clk) refresh_cnt = 19'd3;
    @(negedge clk) refresh_cnt = 19'd0;
    sidx = (sidx == 4) ? 0 : sidx + 1;
    @(negedge clk);
    check("scan_slot", {an, seg}, model(shown, sidx));
  endtask

  task automatic show_all();
    check("slot_now", {an, seg}, model(shown, sidx));
    for (int t = 0; t < 5; t++) tick();
  endtask

  task automatic run_conv(input int v, input bit mid_tick, input bit hold, input int abort_at);
    int busy_n = 0, done_at = 0, dones = 0, next_shown = shown;
    @(negedge clk);
    value_in = 16'(v);
    load     = 1'b1;
    exp_q.push_back(v);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!hold) load = 1'b0;
      refresh_cnt = 19'd0;
      if (busy) busy_n++;
      if (done) begin
        dones++;
        if (done_at == 0) done_at = c;
        if (exp_q.size() > 0) next_shown = exp_q.pop_front();
        load = 1'b0;
      end
      if (c == 4 && mid_tick) begin
        refresh_cnt = 19'd3;
        sidx = (sidx == 4) ? 0 : sidx + 1;
      end
      if (c == 5 && hold) value_in = 16'd200;
      if (c == 8) check("hold_display", {an, seg}, model(shown, sidx));
      if (c == abort_at) begin
        rst = 1'b0;
        refresh_cnt = 19'd3;
      end
      if (c == abort_at + 1) rst = 1'b1;
    end
    if (abort_at > 0) begin
      check("abort_no_done", dones, 0);
      check("abort_busy", busy, 0);
      check("abort_pending", exp_q.size(), 1);
      exp_q.delete();
      sidx  = 0;
      shown = 0;
      check("abort_anseg", {an, seg}, {8'hFE, 7'b1000000});
    end else begin
      check("busy_cycles", busy_n, 17);
      check("done_cycle", done_at, 17);
      check("done_count", dones, 1);
      shown = next_shown;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; load = 1'b0; value_in = 16'd0; refresh_cnt = 19'd0;
    repeat (2) @(negedge clk);
    check("rst_an", an, 8'hFE);
    check("rst_seg", seg, 7'b1000000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    show_all();
    // a count below the tick value must not advance the scan
    @(negedge clk) refresh_cnt = 19'd2;
    @(negedge clk) refresh_cnt = 19'd0;
    @(negedge clk) check("no_tick", {an, seg}, model(shown, sidx));

    run_conv(12345, 1'b0, 1'b0, 0); show_all();
    run_conv(65535, 1'b1, 1'b0, 0); show_all();
    run_conv(0,     1'b0, 1'b0, 0); show_all();
    run_conv(7,     1'b0, 1'b0, 0); show_all();
    run_conv(100,   1'b0, 1'b1, 0); show_all();
    run_conv(999,   1'b0, 1'b0, 8); show_all();
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
